fastmul_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 16x16 fast multiplier.
- Accepts WIDTH-bit operand pairs under a valid/ready handshake and returns the exact 2*WIDTH-bit product STAGES cycles later, at one result per cycle.
- Supports per-transaction signed/unsigned mode and a sideband tag.
- Sits between the Wishbone/LA control logic and the user I/O in the user project wrapper.

---
 rtl/fastmul_pipe.sv | 272 +++++++++++++++++++++++++++
 tb/tb_fastmul_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fastmul_pipe.sv
// fastmul_pipe -- pipelined WIDTH x WIDTH multiplier with valid/ready handshake.
//
// Returns the exact 2*WIDTH-bit product of each accepted operand pair STAGES
// register stages after acceptance, one result per cycle when the consumer is
// ready. Each operation carries its own signed/unsigned mode and a sideband tag.
//
// Parameters:
//   WIDTH  operand width, 8..32, multiple of 4 (default 16)
//   STAGES pipeline register stages from input to output, 1..4 (default 3)
//   TAG_W  sideband tag width (default 4)
//
// Ports:
//   wb_clk_i   clock, all state updates on the rising edge
//   wb_rst_i   asynchronous active-high reset, discards everything in flight
//   in_valid   operand pair present
//   in_ready   pipeline advances this cycle (depends on out_valid/out_ready only)
//   in_a/in_b  multiplicand / multiplier
//   in_signed  1 = two's-complement operands, 0 = unsigned
//   in_tag     sideband tag, returned unmodified with the result
//   in_acc     (FASTMUL_ACC_EN only) add the running accumulator to this result
//   out_valid  result present
//   out_ready  consumer takes the result this cycle
//   out_y      product (or accumulated product)
//   out_tag    tag belonging to out_y
//   busy       any stage holds a valid operation
//
// Optional feature macro: FASTMUL_ACC_EN adds the in_acc port and an internal
// accumulator that is updated with out_y on every output handshake.

module fastmul_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef FASTMUL_ACC_EN
  input  logic               in_acc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_y,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  // Four half-width unsigned sub-products plus the signed-mode correction.
  // hl = a_hi*b_lo, lh = a_lo*b_hi.
  typedef struct packed {
    logic [WIDTH-1:0] hh;
    logic [WIDTH-1:0] hl;
    logic [WIDTH-1:0] lh;
    logic [WIDTH-1:0] ll;
    logic [WIDTH-1:0] corr;
  } pp_t;

  // Carry-save pair: product = s + c (mod 2^W2).
  typedef struct packed {
    logic [W2-1:0] s;
    logic [W2-1:0] c;
  } cs_t;

  logic          adv;
  logic          prev_v;
  logic [TAG_W-1:0] prev_tag;
  logic          feed_busy;
  logic [W2-1:0] prod_c;
  logic [W2-1:0] result_c;
  pp_t           pp_c;

  // Global advance: everything shifts when the output slot is free or is
  // being drained this cycle, otherwise the whole pipe holds.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign busy     = out_valid | feed_busy;

  // Reduces the four shifted sub-products and the negated correction to a
  // carry-save pair with two 3:2 levels. The "+1" of the two's-complement
  // negation of the correction rides in the free bit 0 of the first carry
  // vector, so no extra adder is needed.
  function automatic cs_t compress(input pp_t pp);
    logic [W2-1:0] x0, x1, x2, x3, s1, m1, c1, s2, m2;
    cs_t r;
    x0 = {pp.hh, pp.ll};
    x1 = {{WIDTH{1'b0}}, pp.lh} << H;
    x2 = {{WIDTH{1'b0}}, pp.hl} << H;
    x3 = ~{pp.corr, {WIDTH{1'b0}}};
    s1 = x0 ^ x1 ^ x2;
    m1 = (x0 & x1) | (x0 & x2) | (x1 & x2);
    c1 = (m1 << 1) | {{(W2-1){1'b0}}, 1'b1};
    s2 = s1 ^ c1 ^ x3;
    m2 = (s1 & c1) | (s1 & x3) | (c1 & x3);
    r.s = s2;
    r.c = m2 << 1;
    return r;
  endfunction

  // Final carry-propagate add of a carry-save pair.
  function automatic logic [W2-1:0] cpa(input cs_t x);
    return x.s + x.c;
  endfunction

  // Sub-product generation. For signed operands the bit patterns are
  // multiplied as unsigned, then a_sign*B*2^W and b_sign*A*2^W are removed
  // (Baugh-Wooley style). The a_sign*b_sign*2^(2W) term vanishes modulo
  // 2^(2W), and only the low WIDTH bits of the correction survive the
  // shift by WIDTH, so the correction is kept WIDTH bits wide.
  always_comb begin
    pp_c      = '0;
    pp_c.ll   = {{H{1'b0}}, in_a[H-1:0]}     * {{H{1'b0}}, in_b[H-1:0]};
    pp_c.lh   = {{H{1'b0}}, in_a[H-1:0]}     * {{H{1'b0}}, in_b[WIDTH-1:H]};
    pp_c.hl   = {{H{1'b0}}, in_a[WIDTH-1:H]} * {{H{1'b0}}, in_b[H-1:0]};
    pp_c.hh   = {{H{1'b0}}, in_a[WIDTH-1:H]} * {{H{1'b0}}, in_b[WIDTH-1:H]};
    pp_c.corr = ((in_signed & in_a[WIDTH-1]) ? in_b : '0)
              + ((in_signed & in_b[WIDTH-1]) ? in_a : '0);
  end

  // Datapath cut placement. The last stage is always the output register
  // below; earlier stages hold the sub-products, then the carry-save pair,
  // and a fourth stage is a plain retiming copy of the carry-save pair.
  generate
    if (STAGES == 1) begin : g_cut1
      assign prod_c = cpa(compress(pp_c));
    end else if (STAGES == 2) begin : g_cut2
      pp_t pp_q;

      // Sub-product register; the compressor and final add follow it.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          pp_q <= '0;
        end else if (adv) begin
          pp_q <= pp_c;
        end
      end

      assign prod_c = cpa(compress(pp_q));
    end else begin : g_cut3
      pp_t pp_q;
      cs_t cs_q;

      // Sub-product register followed by the carry-save register.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          pp_q <= '0;
          cs_q <= '0;
        end else if (adv) begin
          pp_q <= pp_c;
          cs_q <= compress(pp_q);
        end
      end

      if (STAGES >= 4) begin : g_retime
        cs_t cs_r;

        // Extra stage with no logic of its own, available for retiming.
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
          if (wb_rst_i) begin
            cs_r <= '0;
          end else if (adv) begin
            cs_r <= cs_q;
          end
        end

        assign prod_c = cpa(cs_r);
      end else begin : g_direct
        assign prod_c = cpa(cs_q);
      end
    end
  endgenerate

`ifdef FASTMUL_ACC_EN
  logic          prev_acc;
  logic [W2-1:0] acc_q;
  logic [W2-1:0] acc_fwd;

  // When the output register reloads on the same edge as a handshake, the
  // result being popped is the accumulator value the next result must see.
  assign acc_fwd  = (out_valid & out_ready) ? out_y : acc_q;
  assign result_c = prev_acc ? (acc_fwd + prod_c) : prod_c;

  // Accumulator follows out_y on each handshake only, so a stalled result
  // is folded in exactly once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      acc_q <= '0;
    end else if (out_valid & out_ready) begin
      acc_q <= out_y;
    end
  end
`else
  assign result_c = prod_c;
`endif

  // Control sideband (valid, tag, accumulate flag) for the stages ahead of
  // the output register. With a single stage the inputs feed it directly.
  generate
    if (STAGES == 1) begin : g_nofeed
      assign prev_v    = in_valid;
      assign prev_tag  = in_tag;
      assign feed_busy = 1'b0;
`ifdef FASTMUL_ACC_EN
      assign prev_acc  = in_acc;
`endif
    end else begin : g_feed
      logic [STAGES-2:0] fv_q;
      logic [TAG_W-1:0]  ftag_q [STAGES-1];
`ifdef FASTMUL_ACC_EN
      logic [STAGES-2:0] facc_q;
`endif

      // Stage-1 valid loads in_valid on every advance, so bubbles travel
      // through the pipe exactly like operations do.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          fv_q <= '0;
          for (int i = 0; i < STAGES - 1; i++) begin
            ftag_q[i] <= '0;
          end
`ifdef FASTMUL_ACC_EN
          facc_q <= '0;
`endif
        end else if (adv) begin
          fv_q[0]   <= in_valid;
          ftag_q[0] <= in_tag;
`ifdef FASTMUL_ACC_EN
          facc_q[0] <= in_acc;
`endif
          for (int i = 1; i < STAGES - 1; i++) begin
            fv_q[i]   <= fv_q[i-1];
            ftag_q[i] <= ftag_q[i-1];
`ifdef FASTMUL_ACC_EN
            facc_q[i] <= facc_q[i-1];
`endif
          end
        end
      end

      assign prev_v    = fv_q[STAGES-2];
      assign prev_tag  = ftag_q[STAGES-2];
      assign feed_busy = |fv_q;
`ifdef FASTMUL_ACC_EN
      assign prev_acc  = facc_q[STAGES-2];
`endif
    end
  endgenerate

  // Output register. Data and tag only reload with a valid operation, so
  // they stay put through bubbles as well as through stalls.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= prev_v;
      if (prev_v) begin
        out_y   <= result_c;
        out_tag <= prev_tag;
      end
    end
  end

endmodule

// File: tb/tb_fastmul_pipe.sv
// tb_fastmul_pipe -- directed bench for fastmul_pipe at WIDTH=16, STAGES=3.
// Inputs change 1 time unit after the rising edge and outputs are read there.

module tb_fastmul_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_tag;
  logic        busy;
`ifdef FASTMUL_ACC_EN
  logic        in_acc;
  logic        acc_sel = 1'b0;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [35:0] exp_q [$];
  logic [35:0] e;
  logic [15:0] ra, rb;
  logic        rs;
  logic [3:0]  rt;

  always #5 clk = ~clk;

  fastmul_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_signed(in_signed),
    .in_tag   (in_tag),
`ifdef FASTMUL_ACC_EN
    .in_acc   (in_acc),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  // Independent reference: native 64-bit multiply of the extended operands.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    longint sa, sb, p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({48'd0, a});
      sb = longint'({48'd0, b});
    end
    p = sa * sb;
    return p[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [3:0] tag);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = tag;
`ifdef FASTMUL_ACC_EN
    in_acc    = acc_sel;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic s, input logic [3:0] tag);
    drive(v, a, b, s, tag);
    step();
  endtask

  task automatic checkResult(input string name, input logic [31:0] y, input logic [3:0] tag);
    checkOutput({name, "_valid"}, out_valid, 1'b1);
    checkOutput(name, {out_tag, out_y}, {tag, y});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);

    // Reset state
    #12;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_out_y", out_y, 32'h0);
    checkOutput("rst_out_tag", out_tag, 4'h0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Latency: unsigned max*max, result after the third edge
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 4'd5);
    checkOutput("lat_e0_valid", out_valid, 1'b0);
    checkOutput("lat_e0_busy", busy, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkOutput("lat_e1_valid", out_valid, 1'b0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkResult("lat_umax", 32'hFFFE0001, 4'd5);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkOutput("lat_drain_valid", out_valid, 1'b0);
    checkOutput("lat_drain_busy", busy, 1'b0);

    // Signed boundaries and a mode change every cycle
    applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b1, 4'd1);
    applyStimulus(1'b1, 16'hFFFF, 16'h0002, 1'b1, 4'd2);
    applyStimulus(1'b1, 16'hFFFF, 16'h0002, 1'b0, 4'd3);
    checkResult("s_min_min", 32'h40000000, 4'd1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkResult("s_neg1_2", 32'hFFFFFFFE, 4'd2);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkResult("u_ffff_2", 32'h0001FFFE, 4'd3);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkOutput("mode_drain_valid", out_valid, 1'b0);

    // Back-to-back stream of 100 random pairs
    for (int i = 0; i < 100 + STAGES - 1; i++) begin
      if (i < 100) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom_range(0, 1));
        rt = 4'($urandom);
        exp_q.push_back({rt, ref_mul(ra, rb, rs)});
        drive(1'b1, ra, rb, rs, rt);
      end else begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
      end
      step();
      if (i >= STAGES - 1) begin
        checkOutput("stream_valid", out_valid, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("stream_data", {out_tag, out_y}, e);
        end
      end
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkOutput("stream_drain_valid", out_valid, 1'b0);

    // Five-cycle output stall with a new operation waiting at the input
    applyStimulus(1'b1, 16'h1234, 16'h5678, 1'b0, 4'd6);
    applyStimulus(1'b1, 16'hFFFF, 16'h8000, 1'b1, 4'd7);
    applyStimulus(1'b1, 16'h00FF, 16'hFF00, 1'b0, 4'd8);
    checkResult("stall_pre", 32'h06260060, 4'd6);
    drive(1'b1, 16'h8000, 16'h0001, 1'b1, 4'd9);
    out_ready = 1'b0;
    #1;
    checkOutput("stall_in_ready0", in_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      checkResult("stall_hold", 32'h06260060, 4'd6);
      checkOutput("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("stall_release_ready", in_ready, 1'b1);
    step();
    checkResult("stall_b", 32'h00008000, 4'd7);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkResult("stall_c", 32'h00FE0100, 4'd8);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkResult("stall_d", 32'hFFFF8000, 4'd9);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkOutput("stall_drain_valid", out_valid, 1'b0);

    // Asynchronous reset with three operations in flight
    applyStimulus(1'b1, 16'd1, 16'd2, 1'b0, 4'd10);
    applyStimulus(1'b1, 16'd3, 16'd4, 1'b1, 4'd11);
    applyStimulus(1'b1, 16'd5, 16'd6, 1'b0, 4'd12);
    checkResult("arst_pre", 32'd2, 4'd10);
    checkOutput("arst_pre_busy", busy, 1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", out_valid, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_out_y", out_y, 32'h0);
    checkOutput("arst_out_tag", out_tag, 4'h0);
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("arst_no_stale", out_valid, 1'b0);
      checkOutput("arst_idle_busy", busy, 1'b0);
    end

`ifdef FASTMUL_ACC_EN
    // Accumulator: 12, then 12+30, then 42+0xFFFE0001, with a stall on 42
    acc_sel = 1'b0;
    applyStimulus(1'b1, 16'd3, 16'd4, 1'b0, 4'd1);
    acc_sel = 1'b1;
    applyStimulus(1'b1, 16'd5, 16'd6, 1'b0, 4'd2);
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 4'd3);
    checkResult("acc_first", 32'd12, 4'd1);
    acc_sel = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkResult("acc_second", 32'd42, 4'd2);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checkResult("acc_stall_hold", 32'd42, 4'd2);
    end
    out_ready = 1'b1;
    step();
    checkResult("acc_third", 32'hFFFE002B, 4'd3);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    checkOutput("acc_drain_valid", out_valid, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
